arf_dump_tx: RTL and testbench

//  Reader side of the architecture register file. On request, takes an atomic

---
 rtl/arf_dump_tx_if.sv | 9 +
 rtl/arf_dump_tx.sv | 105 ++++++++++
 tb/tb_arf_dump_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arf_dump_tx_if.sv
// Byte-stream valid/ready link between the register-file dump engine and the host link.
interface arf_dump_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/arf_dump_tx.sv
// Snapshots the eight GPRs and condition codes on request and streams them as a
// HEADER / 32 register bytes / CC byte / checksum frame over a valid/ready port.
module arf_dump_tx #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] eax,
    input  logic [31:0] ecx,
    input  logic [31:0] edx,
    input  logic [31:0] ebx,
    input  logic [31:0] esp,
    input  logic [31:0] ebp,
    input  logic [31:0] esi,
    input  logic [31:0] edi,
    input  logic [2:0]  cc,
    output logic        busy,
    output logic        done,
    arf_dump_tx_if.master tx
);
    typedef enum logic [2:0] {IDLE, HDR, REG, CCB, SUM} state_t;

    state_t          state;
    logic [7:0][31:0] snap;
    logic [2:0]      cc_snap;
    logic [4:0]      idx;
    logic [7:0]      sum;
    logic            accept;

    assign accept = tx.valid & tx.ready;

    // Byte idx of the snapshot: register idx[4:2], most significant byte first.
    function automatic logic [7:0] reg_byte(input logic [7:0][31:0] s, input logic [4:0] i);
        logic [31:0] w;
        w = s[i[4:2]];
        return w[{~i[1:0], 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            snap     <= '0;
            cc_snap  <= '0;
            idx      <= '0;
            sum      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx.valid <= 1'b0;
            tx.data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= {edi, esi, ebp, esp, ebx, edx, ecx, eax};
                        cc_snap  <= cc;
                        sum      <= '0;
                        busy     <= 1'b1;
                        tx.valid <= 1'b1;
                        tx.data  <= HEADER;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        idx     <= '0;
                        tx.data <= reg_byte(snap, 5'd0);
                        state   <= REG;
                    end
                end
                REG: begin
                    if (accept) begin
                        sum <= sum + tx.data;
                        if (idx == 5'd31) begin
                            tx.data <= {5'b0, cc_snap};
                            state   <= CCB;
                        end else begin
                            idx     <= idx + 5'd1;
                            tx.data <= reg_byte(snap, idx + 5'd1);
                        end
                    end
                end
                CCB: begin
                    if (accept) begin
                        // Present the completed checksum directly; sum itself is not read again.
                        sum     <= sum + tx.data;
                        tx.data <= sum + tx.data;
                        state   <= SUM;
                    end
                end
                SUM: begin
                    if (accept) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        tx.valid <= 1'b0;
                        tx.data  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arf_dump_tx.sv
// Directed checks of the register-file dump framer: framing, checksum, stalls,
// restart rules, back-to-back frames and asynchronous abort.
module tb_arf_dump_tx;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] r [8];
    logic [2:0]  cc;
    logic        busy;
    logic        done;

    arf_dump_tx_if tx_if();

    arf_dump_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .eax(r[0]), .ecx(r[1]), .edx(r[2]), .ebx(r[3]),
        .esp(r[4]), .ebp(r[5]), .esi(r[6]), .edi(r[7]),
        .cc(cc), .busy(busy), .done(done), .tx(tx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] got  [64];
    logic [7:0] expf [35];
    int         n_got;
    int         done_cyc;
    int         busy_cnt;
    int         hold_err;

    // Expected frame from the current register/CC values.
    task automatic build_expected();
        logic [7:0] s;
        s = 8'h00;
        expf[0] = 8'hA5;
        for (int i = 0; i < 32; i++) begin
            expf[1+i] = 8'(r[i/4] >> (8 * (3 - (i % 4))));
            s = s + expf[1+i];
        end
        expf[33] = {5'b0, cc};
        expf[34] = s + expf[33];
    endtask

    function automatic int frame_errs();
        int e;
        e = 0;
        for (int i = 0; i < 35; i++) if (got[i] !== expf[i]) e++;
        return e;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    // Runs from the first frame cycle (a negedge) until Done or the budget expires.
    task automatic collect(input int max_stall, input int budget, input int pulse_cyc, input int mut_cyc);
        int         stall_run;
        bit         have_hold;
        logic [7:0] hold_data;
        n_got = 0; done_cyc = -1; busy_cnt = 0; hold_err = 0;
        stall_run = 0; have_hold = 0; hold_data = 8'h00;
        for (int c = 1; c <= budget; c++) begin
            start = (c == pulse_cyc);
            if (c == mut_cyc) r[0] = r[0] ^ 32'hDEADBEEF;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (busy) busy_cnt++;
            if (have_hold && (!tx_if.valid || tx_if.data !== hold_data)) hold_err++;
            if (tx_if.valid) begin
                if (max_stall == 0 || stall_run >= max_stall || $urandom_range(0, 1) == 1) begin
                    tx_if.ready = 1'b1;
                    stall_run = 0;
                    have_hold = 0;
                    if (n_got < 64) got[n_got] = tx_if.data;
                    n_got++;
                end else begin
                    tx_if.ready = 1'b0;
                    stall_run++;
                    have_hold = 1;
                    hold_data = tx_if.data;
                end
            end else begin
                tx_if.ready = 1'($urandom_range(0, 1));
                have_hold = 0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic set_regs(input logic [31:0] v0, input logic [31:0] vrest, input logic [2:0] c);
        r[0] = v0;
        for (int i = 1; i < 8; i++) r[i] = vrest;
        cc = c;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        n_chk++; if (tx_if.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_if.valid); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (tx_if.data !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_if.data); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_frame();
        set_regs(32'h0, 32'h0, 3'b100);
        build_expected();
        pulse_start();
        collect(0, 60, 0, 0);
        n_chk++; if (n_got !== 35) $display("FAIL zero_len: got %0d want 35", n_got); else n_pass++;
        n_chk++; if (frame_errs() != 0) $display("FAIL zero_frame: got %0d bad bytes want 0", frame_errs()); else n_pass++;
        n_chk++; if (got[33] !== 8'h04) $display("FAIL zero_cc: got %h want 04", got[33]); else n_pass++;
        n_chk++; if (got[34] !== 8'h04) $display("FAIL zero_sum: got %h want 04", got[34]); else n_pass++;
        n_chk++; if (done_cyc !== 36) $display("FAIL zero_done_cyc: got %0d want 36", done_cyc); else n_pass++;
        n_chk++; if (busy_cnt !== 35) $display("FAIL zero_busy_cycles: got %0d want 35", busy_cnt); else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_eax_pattern();
        set_regs(32'h12345678, 32'h0, 3'b000);
        pulse_start();
        collect(0, 60, 0, 0);
        n_chk++; if ({got[1], got[2], got[3], got[4]} !== 32'h12345678)
            $display("FAIL eax_bytes: got %h%h%h%h want 12345678", got[1], got[2], got[3], got[4]); else n_pass++;
        n_chk++; if (got[33] !== 8'h00) $display("FAIL eax_cc: got %h want 00", got[33]); else n_pass++;
        n_chk++; if (got[34] !== 8'h14) $display("FAIL eax_sum: got %h want 14", got[34]); else n_pass++;
    endtask

    task automatic test_stalls();
        r[0] = 32'hCAFE0123; r[1] = 32'h89ABCDEF; r[2] = 32'h01020304; r[3] = 32'h55AA55AA;
        r[4] = 32'h7FFFFFF0; r[5] = 32'h00000080; r[6] = 32'hFEDCBA98; r[7] = 32'h13579BDF;
        cc = 3'b011;
        build_expected();
        pulse_start();
        collect(5, 400, 0, 4);
        n_chk++; if (n_got !== 35) $display("FAIL stall_len: got %0d want 35", n_got); else n_pass++;
        n_chk++; if (frame_errs() != 0) $display("FAIL stall_frame: got %0d bad bytes want 0", frame_errs()); else n_pass++;
        n_chk++; if (hold_err !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_err); else n_pass++;
        n_chk++; if (done_cyc < 36) $display("FAIL stall_done: got cycle %0d want >=36", done_cyc); else n_pass++;
    endtask

    task automatic test_restart();
        set_regs(32'hA1B2C3D4, 32'h11111111, 3'b010);
        build_expected();
        pulse_start();
        collect(0, 60, 8, 0);
        n_chk++; if (n_got !== 35) $display("FAIL restart_len: got %0d want 35", n_got); else n_pass++;
        n_chk++; if (frame_errs() != 0) $display("FAIL restart_frame: got %0d bad bytes want 0", frame_errs()); else n_pass++;
        n_chk++; if (done_cyc !== 36) $display("FAIL restart_done_cyc: got %0d want 36", done_cyc); else n_pass++;
        @(negedge clk);
        n_chk++; if (tx_if.valid !== 1'b0) $display("FAIL restart_queued: got valid %b want 0", tx_if.valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_regs(32'h01010101, 32'h02020202, 3'b001);
        pulse_start();
        collect(0, 60, 0, 0);
        n_chk++; if (done_cyc !== 36) $display("FAIL b2b_first_done: got %0d want 36", done_cyc); else n_pass++;
        set_regs(32'h89ABCDEF, 32'h00000010, 3'b110);
        build_expected();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_chk++; if (tx_if.valid !== 1'b1 || tx_if.data !== 8'hA5)
            $display("FAIL b2b_header: got valid %b data %h want 1 a5", tx_if.valid, tx_if.data); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else n_pass++;
        collect(0, 60, 0, 0);
        n_chk++; if (frame_errs() != 0 || n_got != 35)
            $display("FAIL b2b_frame: got %0d bytes %0d bad want 35 0", n_got, frame_errs()); else n_pass++;
    endtask

    task automatic test_abort();
        bit saw_done;
        set_regs(32'h76543210, 32'h0F0F0F0F, 3'b101);
        build_expected();
        pulse_start();
        tx_if.ready = 1'b1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        tx_if.ready = 1'b0;
        n_chk++; if (tx_if.valid !== 1'b1 || tx_if.data !== expf[10])
            $display("FAIL abort_pending: got valid %b data %h want 1 %h", tx_if.valid, tx_if.data, expf[10]); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (tx_if.valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_async: got valid %b busy %b want 0 0", tx_if.valid, busy); else n_pass++;
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        n_chk++; if (saw_done) $display("FAIL abort_done: got done pulse want none"); else n_pass++;
        pulse_start();
        collect(0, 60, 0, 0);
        n_chk++; if (frame_errs() != 0 || n_got != 35)
            $display("FAIL abort_refresh: got %0d bytes %0d bad want 35 0", n_got, frame_errs()); else n_pass++;
        n_chk++; if (done_cyc !== 36) $display("FAIL abort_done_cyc: got %0d want 36", done_cyc); else n_pass++;
    endtask

    task automatic test_all_ones();
        set_regs(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111);
        pulse_start();
        collect(0, 60, 0, 0);
        n_chk++; if (got[1] !== 8'hFF || got[32] !== 8'hFF)
            $display("FAIL ones_regs: got %h %h want ff ff", got[1], got[32]); else n_pass++;
        n_chk++; if (got[33] !== 8'h07) $display("FAIL ones_cc: got %h want 07", got[33]); else n_pass++;
        n_chk++; if (got[34] !== 8'hE7) $display("FAIL ones_sum: got %h want e7", got[34]); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        tx_if.ready = 1'b0;
        set_regs(32'h0, 32'h0, 3'b000);
        test_reset();
        test_zero_frame();
        test_eax_pattern();
        test_stalls();
        test_restart();
        test_back_to_back();
        test_abort();
        test_all_ones();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
